// File: rtl/parity_seq_ctrl_pkg.sv
// Shared definitions for the parity sequencer: FSM state encoding, chunk
// width of the combinational parity core, requester tags and a helper that
// derives the number of core passes for a given word width.
package parity_seq_ctrl_pkg;

  localparam int CHUNK_W = 7;

  localparam logic TAG_A = 1'b0;
  localparam logic TAG_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(w / CHUNK_W): core passes needed for a w-bit word
  function automatic int num_chunks(input int w);
    return (w + CHUNK_W - 1) / CHUNK_W;
  endfunction

endpackage

// File: rtl/parity_seq_ctrl_if.sv
// Request/result bus of the parity sequencer.
//   req_*_a / req_*_b : two requester ports (valid, data, odd flag, ready)
//   res_*             : tagged result port (valid, parity, tag, ready)
// Handshake rule for every port: a transfer happens on a rising clk edge
// where valid and ready are both high; the source holds valid and its
// payload stable until that edge (a requester may withdraw valid before
// ready without anything being captured).
// master = requesters + result consumer, slave = sequencer.
interface parity_seq_ctrl_if #(
  parameter int WORD_W = 28
);
  logic              req_valid_a;
  logic [WORD_W-1:0] req_data_a;
  logic              req_odd_a;
  logic              req_ready_a;

  logic              req_valid_b;
  logic [WORD_W-1:0] req_data_b;
  logic              req_odd_b;
  logic              req_ready_b;

  logic              res_valid;
  logic              res_parity;
  logic              res_tag;
  logic              res_ready;

  modport master (
    output req_valid_a, req_data_a, req_odd_a,
    input  req_ready_a,
    output req_valid_b, req_data_b, req_odd_b,
    input  req_ready_b,
    input  res_valid, res_parity, res_tag,
    output res_ready
  );

  modport slave (
    input  req_valid_a, req_data_a, req_odd_a,
    output req_ready_a,
    input  req_valid_b, req_data_b, req_odd_b,
    output req_ready_b,
    output res_valid, res_parity, res_tag,
    input  res_ready
  );
endinterface

// File: rtl/parity_seq_ctrl_davio.sv
// parity_davio: 7-input combinational parity core.
//   D : 7-bit input chunk
//   F : XOR of all bits of D
// Positive-Davio expansion f = f|x=0 ^ x & (f|x=0 ^ f|x=1) collapses to
// f = f|x=0 ^ x for parity, since the two cofactors are complements.
module parity_davio (
  input  logic [6:0] D,
  output logic       F
);
  assign F = ^D;
endmodule

// File: rtl/parity_seq_ctrl.sv
// parity_seq_ctrl: sequencer that time-shares one 7-input parity core
// between two requesters and returns the parity of WORD_W-bit words.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   bus       : requester A/B ports and tagged result port (slave side)
//   busy      : high whenever the FSM is not IDLE
//   dbg_state : current FSM state
// A word is captured on a request handshake, zero-padded to whole 7-bit
// chunks, and fed one chunk per cycle through the core while the chunk
// parities are XOR-accumulated. The result (inverted for odd requests) is
// held on the result port until the consumer takes it.
module parity_seq_ctrl
  import parity_seq_ctrl_pkg::*;
#(
  parameter int WORD_W = 28
) (
  input  logic               clk,
  input  logic               rst_n,
  parity_seq_ctrl_if.slave   bus,
  output logic               busy,
  output state_t             dbg_state
);

  localparam int NUM_CHUNKS = num_chunks(WORD_W);
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

  state_t             state, state_next;
  logic [PAD_W-1:0]   word_q;
  logic               odd_q;
  logic               tag_q;
  logic               last_grant;
  logic [CNT_W-1:0]   cnt;
  logic               acc;
  logic               res_valid_q, res_parity_q, res_tag_q;

  logic               grant_a, grant_b;
  logic               accept;
  logic               last_chunk;
  logic [CHUNK_W-1:0] chunk;
  logic               core_out;

  // Round-robin: under contention the requester not served last wins.
  always_comb begin
    grant_a = bus.req_valid_a & (~bus.req_valid_b | (last_grant == TAG_B));
    grant_b = bus.req_valid_b & (~bus.req_valid_a | (last_grant == TAG_A));
  end

  assign bus.req_ready_a = (state == IDLE) & grant_a;
  assign bus.req_ready_b = (state == IDLE) & grant_b;
  // grant already includes valid, so a ready is a completed handshake
  assign accept          = bus.req_ready_a | bus.req_ready_b;

  assign last_chunk = (cnt == CNT_LAST);
  assign chunk      = word_q[cnt*CHUNK_W +: CHUNK_W];

  parity_davio u_core (
    .D (chunk),
    .F (core_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)        state_next = RUN;
      RUN:     if (last_chunk)    state_next = DONE;
      // res_valid is always high in DONE, so res_ready alone completes it
      DONE:    if (bus.res_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q       <= '0;
      odd_q        <= 1'b0;
      tag_q        <= TAG_A;
      last_grant   <= TAG_B;
      cnt          <= '0;
      acc          <= 1'b0;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_tag_q    <= TAG_A;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word_q     <= grant_a ? PAD_W'(bus.req_data_a) : PAD_W'(bus.req_data_b);
            odd_q      <= grant_a ? bus.req_odd_a : bus.req_odd_b;
            tag_q      <= grant_a ? TAG_A : TAG_B;
            last_grant <= grant_a ? TAG_A : TAG_B;
            cnt        <= '0;
            acc        <= 1'b0;
          end
        end
        RUN: begin
          acc <= acc ^ core_out;
          cnt <= last_chunk ? '0 : cnt + 1'b1;
          if (last_chunk) begin
            res_parity_q <= acc ^ core_out ^ odd_q;
            res_tag_q    <= tag_q;
            res_valid_q  <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) res_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.res_valid  = res_valid_q;
  assign bus.res_parity = res_parity_q;
  assign bus.res_tag    = res_tag_q;
  assign busy           = (state != IDLE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_parity_seq_ctrl.sv
// Bench for parity_seq_ctrl: directed steps on a WORD_W=28 instance plus
// random scoreboard streams on instances with WORD_W = 7, 28 and 30.
module tb_parity_seq_ctrl;
  import parity_seq_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst_n;
  logic   busy;
  state_t dbg_state;

  int total = 0;
  int bad = 0;
  int rand_done = 0;

  logic [1:0] exp_q[$];   // {tag, parity} in acceptance order

  parity_seq_ctrl_if #(.WORD_W(28)) m();

  parity_seq_ctrl #(.WORD_W(28)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (m.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [1:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
    check(tag, {30'd0, m.res_tag, m.res_parity}, {30'd0, e});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Evaluate readies for the current drive, take the edge, drop taken valids.
  task automatic hs_edge(output logic took_a, output logic took_b);
    #1;
    took_a = m.req_valid_a & m.req_ready_a;
    took_b = m.req_valid_b & m.req_ready_b;
    if (took_a) exp_q.push_back({TAG_A, ^m.req_data_a ^ m.req_odd_a});
    if (took_b) exp_q.push_back({TAG_B, ^m.req_data_b ^ m.req_odd_b});
    tick();
    if (took_a) m.req_valid_a = 1'b0;
    if (took_b) m.req_valid_b = 1'b0;
  endtask

  // Cycles from the accepting edge until res_valid is seen (bounded).
  task automatic wait_res(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!m.res_valid && k < 40);
  endtask

  task automatic consume();
    m.res_ready = 1'b1;
    tick();
    m.res_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic ta, tb;
    int k;
    logic [1:0] e4;

    rst_n = 1'b0;
    m.req_valid_a = 1'b0; m.req_data_a = '0; m.req_odd_a = 1'b0;
    m.req_valid_b = 1'b0; m.req_data_b = '0; m.req_odd_b = 1'b0;
    m.res_ready = 1'b0;
    tick(); tick();

    // reset state
    check("rst_res_valid", m.res_valid, 0);
    check("rst_res_parity", m.res_parity, 0);
    check("rst_res_tag", m.res_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // 1: A alone, one set bit
    m.req_valid_a = 1'b1; m.req_data_a = 28'h0000001; m.req_odd_a = 1'b0;
    hs_edge(ta, tb);
    check("t1_accept_a", ta, 1);
    check("t1_no_b", tb, 0);
    check("t1_busy", busy, 1);
    wait_res(k);
    check("t1_latency", k, 4);
    check("t1_parity", m.res_parity, 1);
    check("t1_tag", m.res_tag, 0);
    sb_check("t1_sb");
    consume();
    check("t1_res_cleared", m.res_valid, 0);
    check("t1_idle", busy, 0);

    // 2: B alone, all ones, odd; res_ready already high on DONE entry
    m.res_ready = 1'b1;
    m.req_valid_b = 1'b1; m.req_data_b = 28'hFFFFFFF; m.req_odd_b = 1'b1;
    hs_edge(ta, tb);
    check("t2_accept_b", tb, 1);
    check("t2_no_a", ta, 0);
    wait_res(k);
    check("t2_latency", k, 4);
    check("t2_parity", m.res_parity, 1);
    check("t2_tag", m.res_tag, 1);
    sb_check("t2_sb");
    tick();
    check("t2_res_taken", m.res_valid, 0);
    check("t2_idle", busy, 0);
    m.res_ready = 1'b0;

    // 3: contention after reset, A wins first, then alternation
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m.req_valid_a = 1'b1; m.req_data_a = 28'h0000003; m.req_odd_a = 1'b0;
    m.req_valid_b = 1'b1; m.req_data_b = 28'h8000000; m.req_odd_b = 1'b0;
    hs_edge(ta, tb);
    check("t3_first_a", ta, 1);
    check("t3_first_not_b", tb, 0);
    check("t3_b_wait_ready", m.req_ready_b, 0);
    wait_res(k);
    check("t3_a_parity", m.res_parity, 0);
    check("t3_a_tag", m.res_tag, 0);
    sb_check("t3_a_sb");
    consume();
    hs_edge(ta, tb);
    check("t3_then_b", tb, 1);
    wait_res(k);
    check("t3_b_parity", m.res_parity, 1);
    check("t3_b_tag", m.res_tag, 1);
    sb_check("t3_b_sb");
    consume();
    for (int i = 0; i < 4; i++) begin
      if (!m.req_valid_a) begin
        m.req_valid_a = 1'b1; m.req_data_a = 28'($urandom); m.req_odd_a = 1'($urandom_range(0, 1));
      end
      if (!m.req_valid_b) begin
        m.req_valid_b = 1'b1; m.req_data_b = 28'($urandom); m.req_odd_b = 1'($urandom_range(0, 1));
      end
      hs_edge(ta, tb);
      check("t3_alt_grant_a", ta, (i % 2 == 0) ? 1 : 0);
      wait_res(k);
      sb_check("t3_alt_sb");
      consume();
    end
    m.req_valid_a = 1'b0; m.req_valid_b = 1'b0;

    // 4: backpressure in DONE with both requesters pending
    m.req_valid_a = 1'b1; m.req_data_a = 28'($urandom); m.req_odd_a = 1'($urandom_range(0, 1));
    hs_edge(ta, tb);
    check("t4_accept_a", ta, 1);
    e4 = exp_q[0];
    m.req_valid_a = 1'b1; m.req_data_a = 28'($urandom); m.req_odd_a = 1'($urandom_range(0, 1));
    m.req_valid_b = 1'b1; m.req_data_b = 28'($urandom); m.req_odd_b = 1'($urandom_range(0, 1));
    wait_res(k);
    sb_check("t4_sb");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_hold_valid", m.res_valid, 1);
      check("t4_hold_result", {30'd0, m.res_tag, m.res_parity}, {30'd0, e4});
      check("t4_hold_ready_a", m.req_ready_a, 0);
      check("t4_hold_ready_b", m.req_ready_b, 0);
    end
    consume();
    hs_edge(ta, tb);
    check("t4_next_accept_b", tb, 1);
    check("t4_next_busy", busy, 1);
    m.req_valid_a = 1'b0;
    wait_res(k);
    sb_check("t4_b_sb");
    consume();

    // 5: reset two cycles into RUN discards the word
    m.req_valid_a = 1'b1; m.req_data_a = 28'($urandom); m.req_odd_a = 1'($urandom_range(0, 1));
    hs_edge(ta, tb);
    check("t5_accept", ta, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("t5_rst_valid", m.res_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_state", 32'(dbg_state), 32'(IDLE));
    check("t5_rst_parity", m.res_parity, 0);
    check("t5_rst_tag", m.res_tag, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_no_result", m.res_valid, 0);
    end
    m.req_valid_a = 1'b1; m.req_data_a = 28'($urandom); m.req_odd_a = 1'($urandom_range(0, 1));
    m.req_valid_b = 1'b1; m.req_data_b = 28'($urandom); m.req_odd_b = 1'($urandom_range(0, 1));
    hs_edge(ta, tb);
    check("t5_after_rst_a_wins", ta, 1);
    wait_res(k);
    check("t5_latency", k, 4);
    sb_check("t5_a_sb");
    consume();
    hs_edge(ta, tb);
    check("t5_then_b", tb, 1);
    wait_res(k);
    sb_check("t5_b_sb");
    consume();
    check("t5_queue_empty", exp_q.size(), 0);

    // wait for the random streams
    for (int c = 0; c < 60000 && rand_done < 3; c++) tick();
    check("rand_all_done", rand_done, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- random scoreboard streams ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int W = (g == 0) ? 7 : ((g == 1) ? 28 : 30);

    logic   r_rst_n;
    logic   r_busy;
    state_t r_state;

    parity_seq_ctrl_if #(.WORD_W(W)) ri();

    parity_seq_ctrl #(.WORD_W(W)) u_dut (
      .clk       (clk),
      .rst_n     (r_rst_n),
      .bus       (ri.slave),
      .busy      (r_busy),
      .dbg_state (r_state)
    );

    initial begin
      logic [1:0] rq[$];
      logic [1:0] e;
      logic took_a, took_b;
      int issued, got, cyc;

      issued = 0; got = 0; cyc = 0;
      r_rst_n = 1'b0;
      ri.req_valid_a = 1'b0; ri.req_data_a = '0; ri.req_odd_a = 1'b0;
      ri.req_valid_b = 1'b0; ri.req_data_b = '0; ri.req_odd_b = 1'b0;
      ri.res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      r_rst_n = 1'b1;

      while ((issued < 1000 || rq.size() != 0) && cyc < 40000) begin
        if (!ri.req_valid_a && issued < 1000 && $urandom_range(0, 1) == 1) begin
          ri.req_valid_a = 1'b1; ri.req_data_a = W'($urandom); ri.req_odd_a = 1'($urandom_range(0, 1));
        end
        if (!ri.req_valid_b && issued < 1000 && $urandom_range(0, 1) == 1) begin
          ri.req_valid_b = 1'b1; ri.req_data_b = W'($urandom); ri.req_odd_b = 1'($urandom_range(0, 1));
        end
        ri.res_ready = ($urandom_range(0, 3) != 0);
        #1;
        check("rand_one_ready", ri.req_ready_a & ri.req_ready_b, 0);
        took_a = ri.req_valid_a & ri.req_ready_a;
        took_b = ri.req_valid_b & ri.req_ready_b;
        if (took_a) begin rq.push_back({TAG_A, ^ri.req_data_a ^ ri.req_odd_a}); issued++; end
        if (took_b) begin rq.push_back({TAG_B, ^ri.req_data_b ^ ri.req_odd_b}); issued++; end
        if (ri.res_valid && ri.res_ready) begin
          e = (rq.size() != 0) ? rq.pop_front() : 2'bxx;
          check($sformatf("rand_w%0d_result", W), {30'd0, ri.res_tag, ri.res_parity}, {30'd0, e});
          got++;
        end
        @(posedge clk);
        #1;
        if (took_a) ri.req_valid_a = 1'b0;
        if (took_b) ri.req_valid_b = 1'b0;
        cyc++;
      end
      ri.res_ready = 1'b0;
      check($sformatf("rand_w%0d_drained", W), rq.size(), 0);
      check($sformatf("rand_w%0d_count", W), got, issued);
      check($sformatf("rand_w%0d_enough", W), (issued >= 1000) ? 1 : 0, 1);
      rand_done++;
    end
  end

endmodule

// File: doc/parity_seq_ctrl.md
Name: parity_seq_ctrl

Overview:
Time-shares one 7-input combinational parity core between two requesters and computes the parity of WORD_W-bit words. A round-robin arbiter grants one requester. The FSM slices the captured word into 7-bit chunks, one chunk per cycle through the core, and XOR-accumulates the results. The result is returned on a valid/ready port tagged with the requester ID. Sits in front of the Davio parity datapath as its sequencer.

Parameters:
WORD_W, 28, request word width; any value ≥1; top chunk zero-padded (padding does not change parity)
NUM_CHUNKS, ceil(WORD_W/7), localparam; core passes per word
CNT_W, clog2(NUM_CHUNKS) min 1, localparam; chunk counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid_a  in  1  requester A word valid
req_data_a  in  WORD_W  requester A word
req_odd_a  in  1  A wants odd parity (result inverted)
req_ready_a  out  1  A word accepted this cycle
req_valid_b / req_data_b / req_odd_b / req_ready_b: same as A, for requester B
res_valid  out  1  result valid
res_parity  out  1  XOR-reduction of word, inverted if odd requested
res_tag  out  1  0 = A, 1 = B
res_ready  in  1  consumer accepts result
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous, active-low. Reset applies on any clk edge with rst_n=0.
- Reset values: state=IDLE; res_valid=0, res_parity=0, res_tag=0, busy=0; acc=0, cnt=0; last_grant=B, so A wins the first contention.
- States: IDLE, RUN, DONE.
- IDLE, arbitration:
  - Only A valid → grant A; only B valid → grant B.
  - Both valid → grant the one not equal to last_grant.
  - req_ready_x = (state==IDLE) & grant_x. Combinational, at most one high; never high outside IDLE.
- IDLE, on handshake (valid&ready): capture word (zero-extended to 7*NUM_CHUNKS), odd flag and tag. Set cnt=0, acc=0, last_grant=tag → RUN.
- Requester contract: valid and data are held stable until ready. Dropping valid before ready is legal; nothing is captured.
- RUN, each cycle:
  - core input = chunk[cnt] (bits 7*cnt+6 : 7*cnt); acc ^= core output; cnt++.
  - When cnt==NUM_CHUNKS-1: res_parity <= acc ^ core_out ^ odd, res_tag <= tag, res_valid <= 1 → DONE.
- Latency: handshake at edge T → res_valid high from edge T+NUM_CHUNKS (4 cycles at default). NUM_CHUNKS=1: RUN lasts one cycle.
- DONE: res_valid, res_parity and res_tag held stable while res_ready=0. On res_valid&res_ready: res_valid<=0 → IDLE.
- Throughput: new request accepted earliest the cycle after the result handshake. Minimum period NUM_CHUNKS+2 cycles.
- Simultaneous events:
  - res_ready high on the same cycle DONE is entered has no effect; it is sampled only in DONE.
  - Requests arriving during RUN/DONE wait; no queuing.
- Reset mid-operation (RUN or DONE): the in-flight word is discarded, no result is emitted, and all state returns to reset values on that edge.
- No combinational path from req_data_x to any output. The only combinational output paths are req_valid_x → req_ready_x.

Decomposition:
- Shared include (parity_seq_defs): state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2), CHUNK_W=7, TAG_A=1'b0, TAG_B=1'b1.
- One sub-module instance: the existing 7-input Davio parity core parity_davio (ports D[6:0], F). It is fed from a chunk mux indexed by cnt.
- Arbiter logic stays inline; it is ~10 lines and not worth a module.

Test Plan:
1. Reset, then A only with 28'h0000001, odd=0 → req_ready_a high that cycle; res_valid at T+4 with parity=1, tag=0; busy high T+1..result handshake.
2. B only with 28'hFFFFFFF, odd=1 → res_parity=1 (28 ones → 0, inverted), tag=1; req_ready_a stays 0 throughout.
3. After reset, A=28'h0000003 and B=28'h8000000 both valid → A served first (parity 0, tag 0), then B (parity 1, tag 1). Both valid again → A again; grants alternate A,B,A,B.
4. Backpressure: hold res_ready=0 for 10 cycles in DONE → res_valid/res_parity/res_tag stable, req_ready_a/b=0 despite pending valids; release → handshake, next request accepted next cycle.
5. Assert rst_n=0 for one cycle at T+2 of a RUN → res_valid never rises for that word; outputs at reset values; next A request yields correct result at new T+4.
6. 1000 random words, random requesters/odd flags/res_ready stalls → every res_parity equals ^data ^ odd, tags match issue order, no lost or duplicated results; repeat with WORD_W=7 and WORD_W=30.
